// File: rtl/srio_resp_arb.sv
// srio_resp_arb
//   Merges the response streams of three SRIO logical-layer responders
//   (0 doorbell, 1 NREAD, 2 message) onto the single tresp channel of
//   the SRIO core. A whole packet is forwarded from one source before
//   the next source is considered. Sources take turns in round-robin
//   order. A watchdog raises a sticky flag when a granted packet stops
//   moving for too long.
//
// Ports
//   log_clk, log_rst     clock; asynchronous active-high reset
//   s_tvalid/tready/tlast   per-source handshake, bit i is source i
//   s_tdata/tkeep/tuser     per-source payload slices (64/8/32 bits each)
//   m_tresp_*               merged response stream to the SRIO core
//   gnt_o                   granted source index, 2'd3 while idle
//   err_timeout, clr_err    sticky stall-watchdog flag and its clear
module srio_resp_arb #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic         log_clk,
    input  logic         log_rst,
    input  logic [2:0]   s_tvalid,
    output logic [2:0]   s_tready,
    input  logic [2:0]   s_tlast,
    input  logic [191:0] s_tdata,
    input  logic [23:0]  s_tkeep,
    input  logic [95:0]  s_tuser,
    output logic         m_tresp_tvalid,
    input  logic         m_tresp_tready,
    output logic         m_tresp_tlast,
    output logic [63:0]  m_tresp_tdata,
    output logic [7:0]   m_tresp_tkeep,
    output logic [31:0]  m_tresp_tuser,
    output logic [1:0]   gnt_o,
    output logic         err_timeout,
    input  logic         clr_err
);

    localparam int CNT_W = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Counter value one short of the limit: the stalled edge leaving this
    // value is the one on which the counter reaches the limit.
    localparam logic [CNT_W-1:0] CNT_PRE =
        (WDOG_CYCLES > 0) ? CNT_W'(WDOG_CYCLES - 1) : '0;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state;
    logic [1:0]       gnt;
    logic [1:0]       last_gnt;
    logic [1:0]       pick;
    logic [1:0]       cand0;
    logic [1:0]       cand1;
    logic [1:0]       cand2;
    logic [CNT_W-1:0] stall_cnt;
    logic             xfer;
    logic             wdog_hit;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin candidates in priority order, starting just after the
    // previous winner. The last candidate is the fallback; pick is only
    // used when at least one source is valid.
    always_comb begin
        cand0 = rr_next(last_gnt);
        cand1 = rr_next(cand0);
        cand2 = rr_next(cand1);
        if (s_tvalid[cand0]) begin
            pick = cand0;
        end else if (s_tvalid[cand1]) begin
            pick = cand1;
        end else begin
            pick = cand2;
        end
    end

    // Output steering: the granted slice passes straight through while
    // busy; everything is held at zero while idle.
    always_comb begin
        m_tresp_tvalid = 1'b0;
        m_tresp_tlast  = 1'b0;
        m_tresp_tdata  = '0;
        m_tresp_tkeep  = '0;
        m_tresp_tuser  = '0;
        s_tready       = '0;
        if (state == BUSY) begin
            case (gnt)
                2'd0: begin
                    m_tresp_tvalid = s_tvalid[0];
                    m_tresp_tlast  = s_tlast[0];
                    m_tresp_tdata  = s_tdata[63:0];
                    m_tresp_tkeep  = s_tkeep[7:0];
                    m_tresp_tuser  = s_tuser[31:0];
                    s_tready[0]    = m_tresp_tready;
                end
                2'd1: begin
                    m_tresp_tvalid = s_tvalid[1];
                    m_tresp_tlast  = s_tlast[1];
                    m_tresp_tdata  = s_tdata[127:64];
                    m_tresp_tkeep  = s_tkeep[15:8];
                    m_tresp_tuser  = s_tuser[63:32];
                    s_tready[1]    = m_tresp_tready;
                end
                2'd2: begin
                    m_tresp_tvalid = s_tvalid[2];
                    m_tresp_tlast  = s_tlast[2];
                    m_tresp_tdata  = s_tdata[191:128];
                    m_tresp_tkeep  = s_tkeep[23:16];
                    m_tresp_tuser  = s_tuser[95:64];
                    s_tready[2]    = m_tresp_tready;
                end
                default: begin
                end
            endcase
        end
    end

    assign xfer  = m_tresp_tvalid & m_tresp_tready;
    assign gnt_o = gnt;

    // Fires once, on the stalled edge where the counter reaches the limit.
    // The counter keeps saturating afterwards, so a clear issued while the
    // stall persists is not immediately overridden.
    assign wdog_hit = (WDOG_CYCLES != 0) && (state == BUSY) && !xfer
                      && (stall_cnt == CNT_PRE);

    // Arbitration FSM: grant registered in IDLE, held in BUSY until the
    // beat carrying tlast transfers. A source dropping tvalid only stalls.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state     <= IDLE;
            gnt       <= 2'd3;
            last_gnt  <= 2'd2;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (|s_tvalid) begin
                        gnt      <= pick;
                        last_gnt <= pick;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (m_tresp_tlast) begin
                            state <= IDLE;
                            gnt   <= 2'd3;
                        end
                    end else if (stall_cnt != CNT_MAX) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Sticky watchdog flag; a new timeout wins over a coincident clear.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            err_timeout <= 1'b0;
        end else if (wdog_hit) begin
            err_timeout <= 1'b1;
        end else if (clr_err) begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_srio_resp_arb.sv
// tb_srio_resp_arb
//   Self-checking bench for srio_resp_arb (watchdog limit 8). Sources
//   are modelled as packet counters with random per-beat payload. A
//   behavioural model tracks the current owner, the previous winner, the
//   run of stalled cycles and the sticky flag, and predicts every output
//   each cycle. Directed scenarios are followed by a randomized run.
module tb_srio_resp_arb;

    localparam int WDOG = 8;

    logic         log_clk = 1'b0;
    logic         log_rst;
    logic [2:0]   s_tvalid;
    logic [2:0]   s_tready;
    logic [2:0]   s_tlast;
    logic [191:0] s_tdata;
    logic [23:0]  s_tkeep;
    logic [95:0]  s_tuser;
    logic         m_tresp_tvalid;
    logic         m_tresp_tready;
    logic         m_tresp_tlast;
    logic [63:0]  m_tresp_tdata;
    logic [7:0]   m_tresp_tkeep;
    logic [31:0]  m_tresp_tuser;
    logic [1:0]   gnt_o;
    logic         err_timeout;
    logic         clr_err;

    always #5 log_clk = ~log_clk;

    srio_resp_arb #(
        .WDOG_CYCLES(WDOG)
    ) dut (
        .log_clk        (log_clk),
        .log_rst        (log_rst),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tlast        (s_tlast),
        .s_tdata        (s_tdata),
        .s_tkeep        (s_tkeep),
        .s_tuser        (s_tuser),
        .m_tresp_tvalid (m_tresp_tvalid),
        .m_tresp_tready (m_tresp_tready),
        .m_tresp_tlast  (m_tresp_tlast),
        .m_tresp_tdata  (m_tresp_tdata),
        .m_tresp_tkeep  (m_tresp_tkeep),
        .m_tresp_tuser  (m_tresp_tuser),
        .gnt_o          (gnt_o),
        .err_timeout    (err_timeout),
        .clr_err        (clr_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner -1 means nobody holds the channel.
    int owner;
    int last_owner;
    int stall;
    bit err;

    // Source side: beats left in the current packet, valid-drop request,
    // and the payload of the beat currently presented.
    int          rem[3];
    bit          hold[3];
    bit          reload2;
    logic [63:0] cur_data[3];
    logic [7:0]  cur_keep[3];
    logic [31:0] cur_user[3];

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    int seq030[12] = '{3, 0, 0, 3, 1, 1, 3, 2, 2, 3, 0, 0};

    task automatic cmp(input string tag, input string field,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, act, exp);
        end
    endtask

    task automatic new_beat(input int i);
        cur_data[i] = {$urandom, $urandom};
        cur_keep[i] = 8'($urandom);
        cur_user[i] = $urandom;
    endtask

    task automatic drive_sources();
        for (int i = 0; i < 3; i++) begin
            s_tvalid[i]          = (rem[i] > 0) && !hold[i];
            s_tlast[i]           = (rem[i] == 1);
            s_tdata[i*64 +: 64]  = cur_data[i];
            s_tkeep[i*8 +: 8]    = cur_keep[i];
            s_tuser[i*32 +: 32]  = cur_user[i];
        end
    endtask

    task automatic applyStimulus(input bit ready, input bit clr);
        m_tresp_tready = ready;
        clr_err        = clr;
        drive_sources();
    endtask

    task automatic model_reset();
        owner      = -1;
        last_owner = 2;
        stall      = 0;
        err        = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs held
    // across that edge.
    task automatic model_edge();
        bit err_set;
        err_set = 1'b0;
        if (log_rst) begin
            model_reset();
            return;
        end
        if (owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (last_owner + k) % 3;
                if (owner < 0 && s_tvalid[c]) owner = c;
            end
            if (owner >= 0) begin
                last_owner = owner;
                stall      = 0;
            end
        end else if (s_tvalid[owner] && m_tresp_tready) begin
            exp_q.push_back(cur_data[owner]);
            stall = 0;
            rem[owner]--;
            if (rem[owner] == 0 && reload2) rem[owner] = 2;
            new_beat(owner);
            if (s_tlast[owner]) owner = -1;
        end else begin
            stall++;
            if (stall == WDOG) err_set = 1'b1;
        end
        if (err_set) err = 1'b1;
        else if (clr_err) err = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic [1:0]  e_gnt;
        logic        e_valid;
        logic        e_last;
        logic [63:0] e_data;
        logic [7:0]  e_keep;
        logic [31:0] e_user;
        logic [2:0]  e_ready;
        e_gnt   = 2'd3;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_data  = '0;
        e_keep  = '0;
        e_user  = '0;
        e_ready = '0;
        if (owner >= 0) begin
            e_gnt   = 2'(owner);
            e_valid = s_tvalid[owner];
            e_last  = s_tlast[owner];
            e_data  = s_tdata[owner*64 +: 64];
            e_keep  = s_tkeep[owner*8 +: 8];
            e_user  = s_tuser[owner*32 +: 32];
            e_ready = 3'(m_tresp_tready) << owner;
        end
        cmp(tag, "gnt",   64'(gnt_o),          64'(e_gnt));
        cmp(tag, "valid", 64'(m_tresp_tvalid), 64'(e_valid));
        cmp(tag, "last",  64'(m_tresp_tlast),  64'(e_last));
        cmp(tag, "data",  m_tresp_tdata,       e_data);
        cmp(tag, "keep",  64'(m_tresp_tkeep),  64'(e_keep));
        cmp(tag, "user",  64'(m_tresp_tuser),  64'(e_user));
        cmp(tag, "ready", 64'(s_tready),       64'(e_ready));
        cmp(tag, "err",   64'(err_timeout),    64'(err));
    endtask

    // Called at a falling edge with inputs already driven: checks outputs
    // shortly after, advances through the rising edge, returns at the
    // next falling edge.
    task automatic tick(input string tag);
        #1;
        checkOutput(tag);
        if (m_tresp_tvalid === 1'b1 && m_tresp_tready === 1'b1)
            obs_q.push_back(m_tresp_tdata);
        @(posedge log_clk);
        model_edge();
        @(negedge log_clk);
    endtask

    task automatic do_reset();
        log_rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            rem[i]  = 0;
            hold[i] = 1'b0;
        end
        reload2 = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick("reset");
        log_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        log_rst        = 1'b1;
        s_tvalid       = '0;
        s_tlast        = '0;
        s_tdata        = '0;
        s_tkeep        = '0;
        s_tuser        = '0;
        m_tresp_tready = 1'b0;
        clr_err        = 1'b0;
        reload2        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rem[i]  = 0;
            hold[i] = 1'b0;
            new_beat(i);
        end
        model_reset();
        @(negedge log_clk);

        $display("[TB] reset values");
        do_reset();
        #1;
        cmp("reset", "gnt",   64'(gnt_o),          64'd3);
        cmp("reset", "err",   64'(err_timeout),    64'd0);
        cmp("reset", "valid", 64'(m_tresp_tvalid), 64'd0);
        cmp("reset", "ready", 64'(s_tready),       64'd0);

        $display("[TB] single 1-beat packet from source 0");
        rem[0] = 1;
        applyStimulus(1'b1, 1'b0);
        #1;
        cmp("r029", "idle_valid", 64'(m_tresp_tvalid), 64'd0);
        cmp("r029", "idle_gnt",   64'(gnt_o),          64'd3);
        tick("r029_a");
        applyStimulus(1'b1, 1'b0);
        #1;
        cmp("r029", "beat_valid", 64'(m_tresp_tvalid), 64'd1);
        cmp("r029", "beat_last",  64'(m_tresp_tlast),  64'd1);
        cmp("r029", "beat_gnt",   64'(gnt_o),          64'd0);
        cmp("r029", "beat_data",  m_tresp_tdata,       cur_data[0]);
        tick("r029_b");
        applyStimulus(1'b1, 1'b0);
        #1;
        cmp("r029", "after_gnt", 64'(gnt_o), 64'd3);
        tick("r029_c");

        $display("[TB] three sources, continuous 2-beat packets");
        do_reset();
        reload2 = 1'b1;
        for (int i = 0; i < 3; i++) rem[i] = 2;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 1'b0);
            #1;
            cmp("r030", "gnt_seq", 64'(gnt_o), 64'(seq030[c]));
            tick("r030");
        end
        reload2 = 1'b0;

        $display("[TB] source 1, 4 beats, ready toggling");
        do_reset();
        exp_q.delete();
        obs_q.delete();
        rem[1] = 4;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(c % 2 == 1, 1'b0);
            tick("r031");
        end
        cmp("r031", "beats", 64'(obs_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            cmp("r031", "data",
                (k < obs_q.size()) ? obs_q[k] : 64'bx,
                (k < exp_q.size()) ? exp_q[k] : 64'h0);
        end

        $display("[TB] watchdog after source drops valid");
        do_reset();
        rem[0] = 3;
        applyStimulus(1'b1, 1'b0);
        tick("r032_grant");
        applyStimulus(1'b1, 1'b0);
        tick("r032_beat");
        hold[0] = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            applyStimulus(1'b1, 1'b0);
            tick("r032_stall");
        end
        applyStimulus(1'b1, 1'b1);
        #1;
        cmp("r032", "err_before", 64'(err_timeout), 64'd0);
        tick("r032_set");
        applyStimulus(1'b1, 1'b0);
        #1;
        cmp("r032", "err_set_wins", 64'(err_timeout), 64'd1);
        cmp("r032", "gnt_held",     64'(gnt_o),       64'd0);
        tick("r032_hold");
        applyStimulus(1'b1, 1'b0);
        tick("r032_hold");
        applyStimulus(1'b1, 1'b1);
        tick("r032_clr");
        applyStimulus(1'b1, 1'b0);
        #1;
        cmp("r032", "err_cleared", 64'(err_timeout), 64'd0);
        tick("r032_after");
        hold[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0);
            tick("r032_drain");
        end
        applyStimulus(1'b1, 1'b0);
        #1;
        cmp("r032", "released", 64'(gnt_o), 64'd3);
        tick("r032_end");

        $display("[TB] reset in the middle of a source 2 packet");
        do_reset();
        rem[2] = 3;
        applyStimulus(1'b1, 1'b0);
        tick("r033_grant");
        applyStimulus(1'b1, 1'b0);
        tick("r033_beat");
        applyStimulus(1'b1, 1'b0);
        #2;
        log_rst = 1'b1;
        model_reset();
        rem[0] = 1;
        drive_sources();
        #1;
        cmp("r033", "rst_gnt",   64'(gnt_o),          64'd3);
        cmp("r033", "rst_valid", 64'(m_tresp_tvalid), 64'd0);
        cmp("r033", "rst_ready", 64'(s_tready),       64'd0);
        cmp("r033", "rst_data",  m_tresp_tdata,       64'd0);
        @(negedge log_clk);
        applyStimulus(1'b1, 1'b0);
        tick("r033_in_rst");
        log_rst = 1'b0;
        applyStimulus(1'b1, 1'b0);
        tick("r033_idle");
        applyStimulus(1'b1, 1'b0);
        #1;
        cmp("r033", "first_gnt", 64'(gnt_o), 64'd0);
        tick("r033_src0");
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b0);
            tick("r033_drain");
        end

        $display("[TB] randomized traffic");
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit ready;
            if (c == 450) do_reset();
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0)
                    rem[i] = $urandom_range(1, 4);
                hold[i] = ($urandom_range(0, 7) == 0);
            end
            ready = (c >= 300 && c < 316) ? 1'b0 : ($urandom_range(0, 3) != 0);
            applyStimulus(ready, $urandom_range(0, 15) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/srio_resp_arb.md
SRIO_RESP_ARB -- requirements
Module: srio_resp_arb

Interface
REQ-001 Parameter WDOG_CYCLES, default 1024: stall-watchdog limit in log_clk cycles; 0 SHALL disable the watchdog.
REQ-002 log_clk  input  1  clock; all logic SHALL be rising-edge.
REQ-003 log_rst  input  1  reset; SHALL be asynchronous, active-high.
REQ-004 s_tvalid  input  3  per-source response valid; bit i is source i (0 doorbell responder, 1 NREAD responder, 2 message responder).
REQ-005 s_tready  output  3  per-source ready.
REQ-006 s_tlast  input  3  per-source end of packet.
REQ-007 s_tdata  input  192  source i data on bits [64i+63:64i].
REQ-008 s_tkeep  input  24  source i keep on bits [8i+7:8i].
REQ-009 s_tuser  input  96  source i {src_id,des_id} on bits [32i+31:32i].
REQ-010 m_tresp_tvalid / m_tresp_tready / m_tresp_tlast  output/input/output  1 each  merged response stream to the SRIO core.
REQ-011 m_tresp_tdata / m_tresp_tkeep / m_tresp_tuser  output  64/8/32  merged payload.
REQ-012 gnt_o  output  2  current grant index; 2'd3 when idle.
REQ-013 err_timeout  output  1  sticky watchdog flag.
REQ-014 clr_err  input  1  synchronous clear of err_timeout.

Function
REQ-015 The block SHALL use a two-state FSM: IDLE and BUSY.
REQ-016 In IDLE, if any s_tvalid bit is set, the block SHALL register a grant and enter BUSY on the next edge; m_tresp_tvalid SHALL be 0 and every s_tready bit 0 while in IDLE.
REQ-017 Grant selection SHALL be round-robin: search order starts at (last_gnt+1) mod 3 and wraps; last_gnt updates to the new grant.
REQ-018 In BUSY, m_tresp_tvalid/tlast/tdata/tkeep/tuser SHALL combinationally equal the granted source's slice; s_tready[gnt] SHALL equal m_tresp_tready and all other s_tready bits SHALL be 0.
REQ-019 A beat SHALL transfer only when m_tresp_tvalid and m_tresp_tready are both 1.
REQ-020 The grant SHALL be held for the whole packet; BUSY->IDLE SHALL occur on the edge where a beat with tlast=1 transfers.
REQ-021 Arbitration latency: one IDLE cycle between consecutive packets; the first beat of a packet SHALL be presented the cycle after the request is first seen in IDLE.
REQ-022 When not BUSY, m_tresp_tdata/tkeep/tuser/tlast SHALL drive 0.
REQ-023 A source dropping s_tvalid mid-packet SHALL NOT release the grant.
REQ-024 Stall counter: in BUSY, increments each cycle without a transfer and clears on any transfer or on IDLE; width ceil(log2(WDOG_CYCLES+1)), saturating.
REQ-025 When the stall counter reaches WDOG_CYCLES (WDOG_CYCLES!=0), err_timeout SHALL set and remain set; the grant SHALL NOT be released.
REQ-026 clr_err SHALL clear err_timeout on the next edge; if set and clear coincide, set SHALL win.

Reset
REQ-027 On log_rst assertion: state IDLE, last_gnt 2 (source 0 wins first), gnt_o 3, stall counter 0, err_timeout 0, all s_tready 0, m_tresp_tvalid 0.
REQ-028 Reset mid-packet SHALL abandon the packet; no beat SHALL transfer during or after reset until a fresh grant.

Verification
REQ-029 Single source 0, 1-beat packet, m_tresp_tready=1 -> beat appears one cycle after request, tlast=1, gnt_o 0 then 3.
REQ-030 All three sources valid continuously with 2-beat packets -> grant order 0,1,2,0; one idle cycle between packets; no interleaving.
REQ-031 Source 1 granted, m_tresp_tready toggled every other cycle over 4-beat packet -> exactly 4 transfers, data matches s_tdata[127:64] in order.
REQ-032 WDOG_CYCLES=8, granted source deasserts s_tvalid after first beat -> err_timeout rises after 8 stall cycles, gnt_o unchanged; clr_err clears it.
REQ-033 log_rst asserted mid-packet of source 2 -> all outputs at reset values immediately; after release, source 0 granted first if requesting.
